// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator: accepts one received symbol per cycle,
// highest-degree coefficient first, and Horner-evaluates r(x) at the 2t
// consecutive roots alpha^(FCR+i). After the last symbol of a codeword, the
// syndrome vector and an any-nonzero flag are held under a valid/ready handshake.
module rs_syndrome_calc #(
    parameter int           M         = 8,
    parameter int           K         = 223,
    parameter int           T         = 16,
    parameter logic [M:0]   PRIM_POLY = 9'h11D,
    parameter int           FCR       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M-1:0]         data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*T*M-1:0]     syndromes,
    output logic                 error_detected,
    output logic                 syn_valid,
    input  logic                 syn_ready,
    output logic [7:0]           symbol_count
);

    localparam int        N    = (1 << M) - 1;
    localparam int        NSYN = 2 * T;
    localparam logic [7:0] LAST = 8'(N - 1);

    if (N - K != 2 * T) begin : g_param_check
        $error("rs_syndrome_calc: n - k must equal 2*t");
    end

    // Multiply by alpha (x) modulo the field polynomial.
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
    endfunction

    // General GF(2^m) product; with a constant operand it folds to an XOR network.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] x;
        acc = '0;
        x   = a;
        for (int j = 0; j < M; j++) begin
            if (b[j]) acc = acc ^ x;
            x = gf_xtime(x);
        end
        return acc;
    endfunction

    // alpha^e, evaluated at elaboration for the per-syndrome root constants.
    function automatic logic [M-1:0] gf_alpha_pow(input int e);
        logic [M-1:0] x;
        x = M'(1);
        for (int j = 0; j < (e % N); j++) x = gf_xtime(x);
        return x;
    endfunction

    typedef enum logic {ACCUM, HOLD} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [M-1:0]  syn_q [NSYN];
    logic [M-1:0]  syn_d [NSYN];
    logic          err_q;
    logic          err_any;
    logic          accept;
    logic          last_accept;

    // Per-syndrome Horner step; the first symbol loads directly so no clear cycle is needed.
    for (genvar g = 0; g < NSYN; g++) begin : g_syn
        localparam logic [M-1:0] ROOT = gf_alpha_pow(FCR + g);
        assign syn_d[g] = (cnt_q == 8'd0) ? data_in : (gf_mul(syn_q[g], ROOT) ^ data_in);
        assign syndromes[g*M +: M] = syn_q[g];
    end

    // Error flag from the post-update syndromes so it is ready together with syn_valid.
    always_comb begin
        err_any = 1'b0;
        for (int i = 0; i < NSYN; i++) err_any = err_any | (|syn_d[i]);
    end

    // Next-state and handshake outputs for the ACCUM/HOLD controller.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        syn_valid   = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d       = 8'd0;
                        last_accept = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                syn_valid = 1'b1;
                if (syn_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, count, syndrome and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state_q <= ACCUM;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            // NOTE: the syndrome array is reset because the outputs must read zero during reset.
            syn_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept)      syn_q <= syn_d;
            if (last_accept) err_q <= err_any;
        end
    end

    assign error_detected = err_q;
    assign symbol_count   = cnt_q;

endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Front-end of the Reed-Solomon RS(255,223) decoder path: accepts a received codeword one symbol per cycle in transmission order and computes all 2t syndromes S_i = r(α^(FCR+i)), i = 0..2t-1, by per-syndrome Horner accumulation over GF(2^8).

- On the last symbol it presents the full syndrome vector and an error-detected flag under a valid/ready handshake.
- Downstream consumers are the key-equation solver, or a pass-through path when no error is flagged.

## Interface
Parameters:
- m, 8: symbol width in bits; n = 2^m - 1 = 255 symbols per codeword.
- k, 223: message symbols (informational only; n - k must equal 2*t).
- t, 16: correctable symbols; 2*t = 32 syndromes.
- PRIM_POLY, 9'h11D: field primitive polynomial x^8+x^4+x^3+x^2+1; α = 0x02.
- FCR, 0: first consecutive root exponent of the generator polynomial.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  m  received symbol.
- in_valid  in  1  data_in valid this cycle.
- in_ready  out  1  block accepts a symbol this cycle.
- syndromes  out  2*t*m  flat vector; S_i occupies bits [i*m +: m].
- error_detected  out  1  OR-reduction of all syndromes ≠ 0; valid with syn_valid.
- syn_valid  out  1  syndromes/error_detected valid and held.
- syn_ready  in  1  downstream consumes the result.
- symbol_count  out  8  symbols accepted in the current codeword (0..254).

## Operation
- Symbol order: first accepted symbol is coefficient r_254 (highest degree), last is r_0, matching encoder output order (message then parity, highest parity register first).
- Accept = in_valid & in_ready.
- Per accept, for each i: if symbol_count == 0 then S_i <= data_in, else S_i <= (S_i ⊗ α^(FCR+i)) ⊕ data_in.
  - ⊗ is a GF(2^8) constant multiplier; the constants α^(FCR+i) are derived at elaboration from PRIM_POLY.
  - Loading on the first symbol removes the need for a clear cycle.
- FSM, 2 states:
  - ACCUM: in_ready = 1, syn_valid = 0. Each accept increments symbol_count. An accept while symbol_count == 254 goes to HOLD with symbol_count <= 0.
  - HOLD: in_ready = 0, syn_valid = 1; syndromes and error_detected frozen. syn_ready = 1 goes to ACCUM.
- error_detected is registered and computed from the post-update syndromes, so it is valid on the same cycle syn_valid rises.
- In_valid while in_ready = 0 is ignored: no state change, no symbol loss accounting.
- in_valid gaps inside a codeword are legal; accumulation simply pauses.
- Arithmetic is XOR-only, width m throughout; there is no carry and no wrap beyond symbol_count 254 → 0.

## Timing
- Reset (async assert, takes effect immediately):
  - state = ACCUM, symbol_count = 0, all syndromes = 0.
  - syn_valid = 0, error_detected = 0, in_ready = 1 after reset release.
- Latency: syn_valid rises the cycle after the 255th accept, i.e. 1 clock.
- Throughput: 255 accept cycles plus at least 1 HOLD cycle per codeword. With syn_ready tied high, HOLD lasts exactly 1 cycle and the next codeword begins the cycle after.
- Handshake: syn_valid stays high and outputs stay stable until the syn_ready cycle. syn_ready asserted while syn_valid = 0 has no effect.
- Reset mid-codeword: the partial codeword is discarded; the next accept is treated as r_254.
- Reset during HOLD drops the pending result.

## Test plan
- 255 symbols of 0x00, syn_ready = 1:
  - syn_valid pulses 1 cycle after the last accept.
  - All S_i = 0x00, error_detected = 0.
- Encoder output for 223 message bytes 0x00..0xDE, followed by its 32 parity bytes:
  - All S_i = 0x00, error_detected = 0.
- All-zero codeword with the last symbol = 0x05:
  - Every S_i = 0x05, error_detected = 1.
- All-zero codeword with the first symbol = 0x01:
  - S_0 = 0x01, S_1 = α^254 = 0x8E, S_2 = α^253 = 0x47.
  - S_i = α^(-i) generally; error_detected = 1.
- Backpressure: hold syn_ready = 0 for 10 cycles after syn_valid, with in_valid = 1 throughout.
  - in_ready stays 0 and syndromes stay stable.
  - symbol_count stays 0; no symbols are accepted.
  - After syn_ready, the next codeword's syndromes match the golden model.
- Assert rst after 100 accepts, then feed a full single-error codeword:
  - Outputs read 0 immediately on rst assertion.
  - The subsequent syndromes match the golden model with no contamination from the partial codeword.
